// File: rtl/bram_tb_pkg.sv
// Shared definitions for the BRAM sweep controller/checker pair: state encoding,
// default bus widths and the address-derived data pattern.
package bram_tb_pkg;

  localparam int ADDR_SIZE_D = 16;
  localparam int WEN_SIZE_D  = 3;
  localparam int DATA_W_D    = 32;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_e;

  function automatic logic [DATA_W_D-1:0] pat(input logic [ADDR_SIZE_D-1:0] a,
                                              input logic [DATA_W_D-1:0]    seed);
    return {{(DATA_W_D-ADDR_SIZE_D){1'b0}}, a} ^ seed;
  endfunction

endpackage

// File: rtl/bram_data_checker_if.sv
// BRAM port bus between the sweep controller / BRAM side and the data checker.
interface bram_data_checker_if #(
  parameter int ADDR_SIZE = bram_tb_pkg::ADDR_SIZE_D,
  parameter int WEN_SIZE  = bram_tb_pkg::WEN_SIZE_D,
  parameter int DATA_W    = bram_tb_pkg::DATA_W_D
);
  logic [ADDR_SIZE-1:0] i_Addr;
  logic                 i_EN;
  logic [WEN_SIZE-1:0]  i_WEN;
  logic [DATA_W-1:0]    i_Rdata;
  logic [DATA_W-1:0]    o_Wdata;

  // master: controller plus BRAM read port; slave: the checker
  modport master (output i_Addr, i_EN, i_WEN, i_Rdata, input o_Wdata);
  modport slave  (input i_Addr, i_EN, i_WEN, i_Rdata, output o_Wdata);
endinterface

// File: rtl/bram_pattern_gen.sv
// Registered address-derived write pattern: zero-extended address XOR seed.
module bram_pattern_gen #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_W-1:0]    seed,
  output logic [DATA_W-1:0]    wdata
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wdata <= '0;
    else       wdata <= DATA_W'(addr) ^ seed;
  end
endmodule

// File: rtl/bram_data_checker.sv
// Follows controller BRAM beats: drives write pattern, checks read data against it,
// and reports beat/error counts, first failing address and protocol violations.
module bram_data_checker import bram_tb_pkg::*; #(
  parameter int ADDR_SIZE = ADDR_SIZE_D,
  parameter int WEN_SIZE  = WEN_SIZE_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int RD_LAT    = 2,
  parameter int ERR_W     = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_Start,
  input  logic [ADDR_SIZE-1:0]   i_Length,
  input  logic [DATA_W-1:0]      i_Seed,
  bram_data_checker_if.slave     bus,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic [ADDR_SIZE-1:0]   o_BeatCnt,
  output logic [ERR_W-1:0]       o_ErrCnt,
  output logic                   o_FirstErrValid,
  output logic [ADDR_SIZE-1:0]   o_FirstErrAddr,
  output logic                   o_ProtoErr
);
  localparam int LW = $clog2(RD_LAT + 1);

  state_e               state;
  logic                 en_d;
  logic [ADDR_SIZE-1:0] len_reg;
  logic [DATA_W-1:0]    seed_reg;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic [LW-1:0]        lat_cnt;
  logic                 en_rise;
  logic                 rd_bad;

  assign en_rise = bus.i_EN & ~en_d;
  assign rd_bad  = bus.i_Rdata != (DATA_W'(pend_addr) ^ seed_reg);

  bram_pattern_gen #(.ADDR_SIZE(ADDR_SIZE), .DATA_W(DATA_W)) u_pat (
    .clk   (clk),
    .rstn  (rstn),
    .addr  (bus.i_Addr),
    .seed  (seed_reg),
    .wdata (bus.o_Wdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      en_d            <= 1'b0;
      len_reg         <= '0;
      seed_reg        <= '0;
      pend_addr       <= '0;
      lat_cnt         <= '0;
      o_Busy          <= 1'b0;
      o_Done          <= 1'b0;
      o_BeatCnt       <= '0;
      o_ErrCnt        <= '0;
      o_FirstErrValid <= 1'b0;
      o_FirstErrAddr  <= '0;
      o_ProtoErr      <= 1'b0;
    end else begin
      en_d <= bus.i_EN;
      // Start overrides everything, including a beat rising on the same cycle.
      if (i_Start) begin
        state           <= RUN;
        len_reg         <= i_Length;
        seed_reg        <= i_Seed;
        o_Busy          <= 1'b1;
        o_Done          <= 1'b0;
        o_BeatCnt       <= '0;
        o_ErrCnt        <= '0;
        o_FirstErrValid <= 1'b0;
        o_FirstErrAddr  <= '0;
        o_ProtoErr      <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (o_BeatCnt == len_reg) begin
              state  <= DONE;
              o_Busy <= 1'b0;
              o_Done <= 1'b1;
            end else if (en_rise) begin
              if (|bus.i_WEN) begin
                o_BeatCnt <= o_BeatCnt + 1'b1;
              end else begin
                pend_addr <= bus.i_Addr;
                lat_cnt   <= LW'(RD_LAT);
                state     <= WAIT;
              end
            end
          end
          WAIT: begin
            if (en_rise) o_ProtoErr <= 1'b1;
            if (lat_cnt == LW'(1)) begin
              o_BeatCnt <= o_BeatCnt + 1'b1;
              state     <= RUN;
              if (rd_bad) begin
                if (o_ErrCnt != '1) o_ErrCnt <= o_ErrCnt + 1'b1;
                if (!o_FirstErrValid) begin
                  o_FirstErrValid <= 1'b1;
                  o_FirstErrAddr  <= pend_addr;
                end
              end
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
          default: ; // IDLE and DONE hold until the next start
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bram_data_checker.sv
// Directed bench for bram_data_checker with a two-stage BRAM read model.
module tb_bram_data_checker;
  import bram_tb_pkg::*;

  localparam int AW = 16;
  localparam int WW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_Start;
  logic [AW-1:0] i_Length;
  logic [DW-1:0] i_Seed;
  logic          o_Busy, o_Done, o_FirstErrValid, o_ProtoErr;
  logic [AW-1:0] o_BeatCnt, o_FirstErrAddr;
  logic [15:0]   o_ErrCnt;

  int checks = 0;
  int errors = 0;

  bram_data_checker_if #(.ADDR_SIZE(AW), .WEN_SIZE(WW), .DATA_W(DW)) bus ();

  bram_data_checker #(.ADDR_SIZE(AW), .WEN_SIZE(WW), .DATA_W(DW), .RD_LAT(2), .ERR_W(16)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_Start         (i_Start),
    .i_Length        (i_Length),
    .i_Seed          (i_Seed),
    .bus             (bus.slave),
    .o_Busy          (o_Busy),
    .o_Done          (o_Done),
    .o_BeatCnt       (o_BeatCnt),
    .o_ErrCnt        (o_ErrCnt),
    .o_FirstErrValid (o_FirstErrValid),
    .o_FirstErrAddr  (o_FirstErrAddr),
    .o_ProtoErr      (o_ProtoErr)
  );

  always #5 clk = ~clk;

  // BRAM model: two registered read stages, optional bit-0 corruption at addr 3 and 6
  logic [DW-1:0] rd1 = '0, rd2 = '0, mseed = '0;
  logic          corrupt_on = 1'b0;
  always @(posedge clk) begin
    if (bus.i_EN)
      rd1 <= pat(bus.i_Addr, mseed) ^
             ((corrupt_on && (bus.i_Addr == 16'd3 || bus.i_Addr == 16'd6)) ? 32'd1 : 32'd0);
    rd2 <= rd1;
  end
  assign bus.i_Rdata = rd2;

  task automatic do_start(input logic [AW-1:0] len, input logic [DW-1:0] seed);
    @(posedge clk); #1;
    i_Start = 1'b1; i_Length = len; i_Seed = seed; mseed = seed;
    @(posedge clk); #1;
    i_Start = 1'b0;
  endtask

  // One beat: address held 2 clk, EN high 1 clk, then idle long enough for a read.
  task automatic beat(input logic [AW-1:0] a, input logic [WW-1:0] w, output logic [DW-1:0] wd);
    bus.i_Addr = a; bus.i_WEN = w;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_EN = 1'b1;
    @(negedge clk) wd = bus.o_Wdata;
    @(posedge clk); #1;
    bus.i_EN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b1; i_Start = 1'b0; i_Length = '0; i_Seed = '0;
    bus.i_Addr = '0; bus.i_EN = 1'b0; bus.i_WEN = '0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_Busy, o_Done, o_BeatCnt, o_ErrCnt, o_FirstErrValid, o_FirstErrAddr, o_ProtoErr, bus.o_Wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b beat=%0d err=%0d fev=%b fea=%0d proto=%b wdata=%h, all required 0",
               o_Busy, o_Done, o_BeatCnt, o_ErrCnt, o_FirstErrValid, o_FirstErrAddr, o_ProtoErr, bus.o_Wdata);
    end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_wd [4] = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003};
    do_start(16'd4, 32'hA5A50000);
    for (int i = 0; i < 4; i++) begin
      beat(AW'(i), 3'b111, wd);
      checks++;
      if (wd !== exp_wd[i]) begin
        errors++; $display("FAIL write_wdata[%0d]: got %h want %h", i, wd, exp_wd[i]);
      end
    end
    checks++;
    if (o_BeatCnt !== 16'd4 || o_Done !== 1'b1 || o_Busy !== 1'b0 || o_ErrCnt !== 16'd0) begin
      errors++; $display("FAIL write_done: beat=%0d done=%b busy=%b err=%0d want 4 1 0 0", o_BeatCnt, o_Done, o_Busy, o_ErrCnt);
    end
    beat(16'd9, 3'b111, wd); // overrun beat after DONE
    checks++;
    if (o_BeatCnt !== 16'd4 || o_Done !== 1'b1) begin
      errors++; $display("FAIL write_overrun: beat=%0d done=%b want 4 1", o_BeatCnt, o_Done);
    end
  endtask

  task automatic test_read(input logic corrupt);
    logic [DW-1:0] wd;
    corrupt_on = corrupt;
    do_start(16'd8, corrupt ? 32'h1234_5600 : 32'hDEAD_0000);
    for (int i = 0; i < 8; i++) beat(AW'(i), 3'b000, wd);
    checks++;
    if (o_BeatCnt !== 16'd8 || o_Done !== 1'b1 || o_Busy !== 1'b0) begin
      errors++; $display("FAIL read_done(c=%b): beat=%0d done=%b busy=%b want 8 1 0", corrupt, o_BeatCnt, o_Done, o_Busy);
    end
    checks++;
    if (o_ErrCnt !== (corrupt ? 16'd2 : 16'd0) || o_FirstErrValid !== corrupt) begin
      errors++; $display("FAIL read_err(c=%b): err=%0d fev=%b want %0d %b", corrupt, o_ErrCnt, o_FirstErrValid, corrupt ? 2 : 0, corrupt);
    end
    checks++;
    if (o_FirstErrAddr !== (corrupt ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL read_first_addr(c=%b): got %0d want %0d", corrupt, o_FirstErrAddr, corrupt ? 3 : 0);
    end
    corrupt_on = 1'b0;
  endtask

  task automatic test_len0;
    @(posedge clk); #1;
    i_Start = 1'b1; i_Length = '0;
    @(posedge clk); #1;
    i_Start = 1'b0;
    @(negedge clk);
    checks++;
    if (o_Done !== 1'b0 || o_Busy !== 1'b1 || o_ErrCnt !== 16'd0 || o_FirstErrValid !== 1'b0) begin
      errors++; $display("FAIL len0_first: done=%b busy=%b err=%0d fev=%b want 0 1 0 0", o_Done, o_Busy, o_ErrCnt, o_FirstErrValid);
    end
    @(negedge clk);
    checks++;
    if (o_Done !== 1'b1 || o_BeatCnt !== 16'd0) begin
      errors++; $display("FAIL len0_done: done=%b beat=%0d want 1 0", o_Done, o_BeatCnt);
    end
    #1;
  endtask

  task automatic test_proto;
    logic [DW-1:0] wd;
    do_start(16'd2, 32'h0F0F_0000);
    bus.i_Addr = 16'd5; bus.i_WEN = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_EN = 1'b1;
    @(posedge clk); #1; bus.i_EN = 1'b0;
    @(posedge clk); #1; bus.i_EN = 1'b1;
    @(posedge clk); #1; bus.i_EN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_ProtoErr !== 1'b1 || o_BeatCnt !== 16'd1 || o_ErrCnt !== 16'd0 || o_Busy !== 1'b1) begin
      errors++; $display("FAIL proto: proto=%b beat=%0d err=%0d busy=%b want 1 1 0 1", o_ProtoErr, o_BeatCnt, o_ErrCnt, o_Busy);
    end
    beat(16'd6, 3'b000, wd);
    checks++;
    if (o_ProtoErr !== 1'b1 || o_BeatCnt !== 16'd2 || o_Done !== 1'b1) begin
      errors++; $display("FAIL proto_sticky: proto=%b beat=%0d done=%b want 1 2 1", o_ProtoErr, o_BeatCnt, o_Done);
    end
  endtask

  task automatic test_restart_reset;
    logic [DW-1:0] wd;
    do_start(16'd8, 32'h0000_1000);
    for (int i = 0; i < 3; i++) beat(AW'(i), 3'b001, wd);
    checks++;
    if (o_BeatCnt !== 16'd3) begin
      errors++; $display("FAIL restart_pre: beat=%0d want 3", o_BeatCnt);
    end
    bus.i_Addr = 16'd3; bus.i_WEN = 3'b001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_Start = 1'b1; i_Length = 16'd8; bus.i_EN = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0; bus.i_EN = 1'b0;
    @(negedge clk);
    checks++;
    if (o_BeatCnt !== 16'd0 || o_Busy !== 1'b1 || o_Done !== 1'b0) begin
      errors++; $display("FAIL restart_clear: beat=%0d busy=%b done=%b want 0 1 0", o_BeatCnt, o_Busy, o_Done);
    end
    @(posedge clk); #1;
    beat(16'd4, 3'b001, wd);
    checks++;
    if (o_BeatCnt !== 16'd1) begin
      errors++; $display("FAIL restart_count: beat=%0d want 1", o_BeatCnt);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_Busy, o_Done, o_BeatCnt, o_ErrCnt, o_FirstErrValid, o_ProtoErr, bus.o_Wdata} !== '0) begin
      errors++; $display("FAIL midrun_reset: busy=%b done=%b beat=%0d err=%0d wdata=%h want all 0",
                         o_Busy, o_Done, o_BeatCnt, o_ErrCnt, bus.o_Wdata);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    beat(16'd5, 3'b001, wd);
    checks++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0 || o_BeatCnt !== 16'd0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b done=%b beat=%0d want 0 0 0", o_Busy, o_Done, o_BeatCnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(1'b0);
    test_read(1'b1);
    test_len0();
    test_proto();
    test_restart_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bram_data_checker.md
Name: bram_data_checker

Overview:
- Downstream companion of the BRAM sweep controller.
- Watches the controller's address, enable and write-enable outputs, and drives the BRAM write-data bus with an address-derived pattern during write sweeps.
- Checks BRAM read data against the same pattern during read sweeps.
- Reports beat count, error count and first failing address to the bench, all in the clk domain.

Parameters:
- ADDR_SIZE, 16, address width; matches the controller.
- WEN_SIZE, 3, byte write-enable width; matches the controller.
- DATA_W, 32, BRAM data width; must be >= ADDR_SIZE.
- RD_LAT, 2, clk cycles from i_EN rising edge to valid i_Rdata; must be >= 1.
- ERR_W, 16, error counter width.

Ports:
- clk  input  1  system clock, shared with the BRAM.
- rstn  input  1  asynchronous active-low reset.
- i_Start  input  1  single-cycle pulse; arms a run and clears all results.
- i_Length  input  ADDR_SIZE  number of beats expected in the run; captured on i_Start.
- i_Seed  input  DATA_W  pattern seed; captured on i_Start.
- i_Addr  input  ADDR_SIZE  BRAM address from the controller.
- i_EN  input  1  BRAM enable from the controller.
- i_WEN  input  WEN_SIZE  BRAM write enable from the controller.
- i_Rdata  input  DATA_W  BRAM read data.
- o_Wdata  output  DATA_W  BRAM write data.
- o_Busy  output  1  run in progress.
- o_Done  output  1  run complete; level signal held until next i_Start.
- o_BeatCnt  output  ADDR_SIZE  beats seen in the current run.
- o_ErrCnt  output  ERR_W  read mismatches; saturating.
- o_FirstErrValid  output  1  at least one mismatch recorded.
- o_FirstErrAddr  output  ADDR_SIZE  address of the first mismatch.
- o_ProtoErr  output  1  sticky; new beat arrived while a read was still pending.

Behaviour:
- Reset: every register and output is 0, state IDLE.
  - Reset mid-run aborts the run with no residual state.
- Pattern: pat(a) = zero-extend(a) XOR seed_reg.
- Write data:
  - o_Wdata <= pat(i_Addr) every clk, in all states (one-cycle latency).
  - i_Addr must be stable for >= 2 clk before each i_EN rise; the controller guarantees this.
- Beat detection: a registered copy of i_EN gives en_rise = i_EN & !en_d.
- States:
  - IDLE: o_Busy=0. On i_Start go to RUN.
  - RUN: o_Busy=1.
    - On en_rise with |i_WEN (write beat): o_BeatCnt +1, no compare.
    - On en_rise with i_WEN==0 (read beat): latch i_Addr into pend_addr, load lat_cnt=RD_LAT, go to WAIT.
    - When o_BeatCnt == len_reg, go to DONE.
  - WAIT:
    - Decrement lat_cnt each clk.
    - When lat_cnt reaches 1, compare i_Rdata against pat(pend_addr) on that cycle, o_BeatCnt +1, return to RUN.
    - The done test is made in RUN on the following cycle.
  - DONE: o_Done=1, o_Busy=0. Stay until i_Start.
- On i_Start in any state:
  - Clear o_BeatCnt, o_ErrCnt, o_FirstErrValid, o_FirstErrAddr and o_ProtoErr.
  - Capture i_Length into len_reg and i_Seed into seed_reg.
  - Go to RUN, which restarts a run that was in progress.
  - o_Done drops on the cycle after i_Start.
- Length 0: RUN sees BeatCnt==0==len_reg on the first cycle; o_Done is high 2 clk after i_Start.
- Mismatch:
  - o_ErrCnt +1, saturating at all-ones with no wrap.
  - If o_FirstErrValid==0: set it and record pend_addr. Later errors do not overwrite the recorded address.
- en_rise while in WAIT: set o_ProtoErr. The new beat is not counted; the pending compare still completes.
- Beats after DONE (controller overran i_Length): ignored. Results remain frozen.
- en_rise on the same cycle as i_Start: i_Start wins; the beat is not counted.
- o_BeatCnt is ADDR_SIZE wide. Because len_reg <= 2^ADDR_SIZE-1, the counter never wraps within a run.

Decomposition:
- Shared package bram_tb_pkg holds:
  - the state encoding (IDLE, RUN, WAIT, DONE);
  - the default ADDR_SIZE, WEN_SIZE and DATA_W constants;
  - a pat() function shared with the controller bench.
- One natural sub-module, bram_pattern_gen: registered pat() for o_Wdata. It is reused by the bench scoreboard.
- The compare and counters stay in the top module.

Test Plan:
- Write sweep, Length=4, Seed=0xA5A50000, WEN=3'b111 → o_Wdata=0xA5A50000..0xA5A50003 at each EN; BeatCnt=4; Done=1; ErrCnt=0.
- Read sweep, Length=8, RD_LAT=2, model BRAM returning pat(addr) → ErrCnt=0, BeatCnt=8, Done=1, FirstErrValid=0.
- Read sweep with data at addr 3 and 6 corrupted (bit 0 flipped) → ErrCnt=2, FirstErrAddr=3, FirstErrValid=1.
- Length=0, then i_Start → Done=1 exactly 2 clk later; BeatCnt=0; no EN required.
- Force EN rises 1 clk apart with RD_LAT=2 → ProtoErr=1 sticky; only the first beat is counted.
- i_Start at beat 3 of a Length=8 run, then reset asserted mid-run → counters clear on restart; all outputs 0 during reset; Busy=0 after release.
